// File: rtl/sram_axi_slave.sv
// -----------------------------------------------------------------------------
// sram_axi_slave
//   AXI4-Lite slave that fronts a single-port synchronous SRAM. Only one
//   transaction is in flight at a time. Reads and writes are arbitrated
//   fairly in IDLE: when both sides ask in the same cycle, the side that was
//   not granted last time wins.
//
// Ports
//   clk, rst                    single clock, synchronous active-high reset
//   AWADDR/AWVALID/AWREADY      write address channel
//   WDATA/WSTRB/WVALID/WREADY   write data channel (WSTRB[i] enables byte i)
//   BRESP/BVALID/BREADY         write response channel
//   ARADDR/ARVALID/ARREADY      read address channel
//   RDATA/RRESP/RVALID/RREADY   read data channel
//   CS/OE/WEB/A/DI              SRAM controls (WEB active-low per byte)
//   DO                          SRAM read data, valid the cycle after a read
//   dbg_state                   current FSM state encoding (state_t)
//
// Handshake semantics: a transfer on any AXI channel happens on the rising
// edge where VALID and READY are both high. READY is only ever raised in
// IDLE and only for the granted channel; a write is taken only when AWVALID
// and WVALID are both high, so AWREADY and WREADY always rise together.
// BVALID/RVALID, once high, stay high with stable payload until the
// matching READY is seen high on a rising edge.
// -----------------------------------------------------------------------------
module sram_axi_slave #(
  parameter int SRAM_AW = 14
) (
  input  logic               clk,
  input  logic               rst,
  // write address
  input  logic [31:0]        AWADDR,
  input  logic               AWVALID,
  output logic               AWREADY,
  // write data
  input  logic [31:0]        WDATA,
  input  logic [3:0]         WSTRB,
  input  logic               WVALID,
  output logic               WREADY,
  // write response
  output logic [1:0]         BRESP,
  output logic               BVALID,
  input  logic               BREADY,
  // read address
  input  logic [31:0]        ARADDR,
  input  logic               ARVALID,
  output logic               ARREADY,
  // read data
  output logic [31:0]        RDATA,
  output logic [1:0]         RRESP,
  output logic               RVALID,
  input  logic               RREADY,
  // SRAM
  output logic               CS,
  output logic               OE,
  output logic [3:0]         WEB,
  output logic [SRAM_AW-1:0] A,
  output logic [31:0]        DI,
  input  logic [31:0]        DO,
  // debug
  output logic [2:0]         dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_WRESP = 3'd2,
    S_RD    = 3'd3,
    S_RCAP  = 3'd4,
    S_RRESP = 3'd5
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  state_t               state_q, state_d;
  logic                 last_grant_wr_q;  // 1: the most recent grant was a write
  logic                 err_q;            // latched decode error of current txn
  logic [3:0]           strb_q;
  logic [SRAM_AW-1:0]   a_q;
  logic [31:0]          di_q;
  logic [31:0]          rdata_q;
  logic [1:0]           bresp_q;
  logic [1:0]           rresp_q;

  logic                 wr_req, rd_req;
  logic                 grant_wr, grant_rd;

  // Any address bit above the SRAM word range means the access misses the
  // memory. ADDR[1:0] is a byte offset and is ignored.
  function automatic logic addr_err(input logic [31:0] addr);
    return (addr >> (SRAM_AW + 2)) != 32'd0;
  endfunction

  // Arbitration: a lone requester is granted; on a tie the side that lost
  // last time wins, so reads and writes alternate under contention.
  assign wr_req   = AWVALID & WVALID;
  assign rd_req   = ARVALID;
  assign grant_wr = (state_q == S_IDLE) & wr_req & (~rd_req | ~last_grant_wr_q);
  assign grant_rd = (state_q == S_IDLE) & rd_req & (~wr_req |  last_grant_wr_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      last_grant_wr_q <= 1'b1;  // reads win the first tie after reset
      err_q           <= 1'b0;
      strb_q          <= 4'h0;
      a_q             <= '0;
      di_q            <= 32'd0;
      rdata_q         <= 32'd0;
      bresp_q         <= RESP_OKAY;
      rresp_q         <= RESP_OKAY;
    end else begin
      state_q <= state_d;

      if (grant_wr) begin
        last_grant_wr_q <= 1'b1;
        a_q             <= AWADDR[SRAM_AW+1:2];
        di_q            <= WDATA;
        strb_q          <= WSTRB;
        err_q           <= addr_err(AWADDR);
      end else if (grant_rd) begin
        last_grant_wr_q <= 1'b0;
        a_q             <= ARADDR[SRAM_AW+1:2];
        err_q           <= addr_err(ARADDR);
      end

      if (state_q == S_WR) begin
        bresp_q <= err_q ? RESP_SLVERR : RESP_OKAY;
      end

      // The SRAM presents DO one cycle after the RD access cycle, i.e. during
      // RCAP; capture it at the end of RCAP so RDATA is stable in RRESP.
      if (state_q == S_RCAP) begin
        rdata_q <= err_q ? 32'd0 : DO;
        rresp_q <= err_q ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    AWREADY = 1'b0;
    WREADY  = 1'b0;
    ARREADY = 1'b0;
    BVALID  = 1'b0;
    RVALID  = 1'b0;
    CS      = 1'b0;
    OE      = 1'b0;
    WEB     = 4'hF;

    case (state_q)
      S_IDLE: begin
        AWREADY = grant_wr;
        WREADY  = grant_wr;
        ARREADY = grant_rd;
        if (grant_wr) begin
          state_d = S_WR;
        end else if (grant_rd) begin
          state_d = S_RD;
        end
      end
      S_WR: begin
        // A decode error suppresses the SRAM access entirely.
        CS      = ~err_q;
        WEB     = err_q ? 4'hF : ~strb_q;
        state_d = S_WRESP;
      end
      S_WRESP: begin
        BVALID = 1'b1;
        if (BREADY) begin
          state_d = S_IDLE;
        end
      end
      S_RD: begin
        CS      = ~err_q;
        OE      = ~err_q;
        state_d = S_RCAP;
      end
      S_RCAP: begin
        CS      = ~err_q;
        OE      = ~err_q;
        state_d = S_RRESP;
      end
      S_RRESP: begin
        RVALID = 1'b1;
        if (RREADY) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign A         = a_q;
  assign DI        = di_q;
  assign RDATA     = rdata_q;
  assign RRESP     = rresp_q;
  assign BRESP     = bresp_q;
  assign dbg_state = state_q;

endmodule
